// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, drives the imem address, flags load-use hazards.
// Latency: imem_data is latched into id_inst one edge after imem_addr is presented; control_sel is combinational.
// Backpressure: a load-use hazard or a halt in ID freezes PC and IF/ID; pc_src=10 holds; redirects flush one slot.
// Optional: define IF_ID_PERF_CNT_EN to add stall_cnt/flush_cnt counters.
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic [1:0]  pc_src,
   input  logic [31:0] branch_target,
   input  logic [31:0] jalr_target,
   input  logic        id_ex_mem_read,
   input  logic [4:0]  id_ex_rd,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic        id_valid,
   output logic        control_sel,
   output logic        halted
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
   localparam logic [1:0] PC_SRC_BR   = 2'b01;
   localparam logic [1:0] PC_SRC_HOLD = 2'b10;
   localparam logic [1:0] PC_SRC_JALR = 2'b11;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_HALT   = 7'b1111111;

   logic [31:0] pc;
   logic [6:0]  id_opcode;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_uses_rs2;
   logic        halt_in_id;
   logic        redirect_taken;

   assign imem_addr = pc;
   assign id_opcode = id_inst[6:0];
   assign id_rs1    = id_inst[19:15];
   assign id_rs2    = id_inst[24:20];

   // Load-use hazard: only R-type, store and branch actually read rs2, so other formats ignore that field.
   always_comb begin
      id_uses_rs2 = 1'b0;
      control_sel = 1'b0;
      if ((id_opcode == OP_REG) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH)) begin
         id_uses_rs2 = 1'b1;
      end
      if (id_valid && !halted && id_ex_mem_read && (id_ex_rd != 5'd0)) begin
         if ((id_ex_rd == id_rs1) || (id_uses_rs2 && (id_ex_rd == id_rs2))) begin
            control_sel = 1'b1;
         end
      end
   end

   // Halt opcode sitting in ID (only a real fetched instruction counts, never the injected NOP).
   assign halt_in_id = id_valid && (id_opcode == OP_HALT);

   // A redirect is only taken when nothing of higher priority freezes the stage this edge.
   assign redirect_taken = !halted && !control_sel && !halt_in_id &&
                           ((pc_src == PC_SRC_BR) || (pc_src == PC_SRC_JALR));

   // PC and IF/ID register update in strict priority: reset, halted, stall, halt-in-ID, pc_src.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         id_inst  <= NOP_INST;
         id_pc    <= 32'h0;
         id_valid <= 1'b0;
         halted   <= 1'b0;
      end else if (halted) begin
         // Sticky: everything frozen until the next reset.
      end else if (control_sel) begin
         // Stall holds regardless of pc_src so the dependent instruction re-evaluates next cycle.
      end else if (halt_in_id) begin
         halted <= 1'b1;
      end else begin
         case (pc_src)
            PC_SRC_BR: begin
               pc       <= branch_target;
               id_inst  <= NOP_INST;
               id_pc    <= 32'h0;
               id_valid <= 1'b0;
            end
            PC_SRC_JALR: begin
               pc       <= {jalr_target[31:1], 1'b0};
               id_inst  <= NOP_INST;
               id_pc    <= 32'h0;
               id_valid <= 1'b0;
            end
            PC_SRC_HOLD: begin
               // Control asked to hold fetch; PC and IF/ID keep their values.
            end
            default: begin
               pc       <= pc + 32'd4;
               id_inst  <= imem_data;
               id_pc    <= pc;
               id_valid <= 1'b1;
            end
         endcase
      end
   end

`ifdef IF_ID_PERF_CNT_EN
   // Performance counters: count stall edges and taken redirects, frozen while halted, wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 32'h0;
         flush_cnt <= 32'h0;
      end else if (!halted) begin
         if (control_sel) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (redirect_taken) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, sequential fetch, load-use stall, redirects, halt, PC wrap.
// Inputs change 1ns after the rising edge; outputs are sampled at that point (after settling).
// Perf counter checks are compiled only when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_stage;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [1:0]  pc_src;
   logic [31:0] branch_target;
   logic [31:0] jalr_target;
   logic        id_ex_mem_read;
   logic [4:0]  id_ex_rd;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        id_valid;
   logic        control_sel;
   logic        halted;
`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   if_id_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .pc_src         (pc_src),
      .branch_target  (branch_target),
      .jalr_target    (jalr_target),
      .id_ex_mem_read (id_ex_mem_read),
      .id_ex_rd       (id_ex_rd),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_valid       (id_valid),
      .control_sel    (control_sel),
      .halted         (halted)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; pc_src = 2'b00; id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
      imem_data = 32'h0000_0013; branch_target = 32'h0; jalr_target = 32'h0;
      step();
      rst = 1'b0;
   endtask

   // Fetch one instruction into IF/ID via a sequential advance.
   task automatic load_id(input logic [31:0] inst);
      id_ex_mem_read = 1'b0; id_ex_rd = 5'd0; pc_src = 2'b00; imem_data = inst;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want 00000000", imem_addr); end
      tests_run++;
      if (id_inst !== 32'h13 || id_pc !== 32'h0 || id_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_ifid: inst %h pc %h valid %b want 00000013 00000000 0", id_inst, id_pc, id_valid);
      end
      tests_run++;
      if (halted !== 1'b0 || control_sel !== 1'b0) begin
         tests_failed++; $display("FAIL reset_flags: halted %b control_sel %b want 0 0", halted, control_sel);
      end
   endtask

   task automatic test_seq_fetch();
      do_reset();
      pc_src = 2'b00; imem_data = 32'h0000_0013;
      step();
      tests_run++;
      if (imem_addr !== 32'h4 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
         tests_failed++; $display("FAIL seq_fetch1: addr %h id_pc %h valid %b want 00000004 00000000 1", imem_addr, id_pc, id_valid);
      end
      step();
      tests_run++;
      if (imem_addr !== 32'h8 || id_pc !== 32'h4 || id_inst !== 32'h13) begin
         tests_failed++; $display("FAIL seq_fetch2: addr %h id_pc %h inst %h want 00000008 00000004 00000013", imem_addr, id_pc, id_inst);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      load_id(32'h0052_8333);              // add x6,x5,x5 ; pc now 4
      id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; pc_src = 2'b00; imem_data = 32'hDEAD_BEEF;
      #1;
      tests_run++;
      if (control_sel !== 1'b1) begin tests_failed++; $display("FAIL stall_rs1: control_sel %b want 1", control_sel); end
      step();
      tests_run++;
      if (imem_addr !== 32'h4 || id_inst !== 32'h0052_8333 || id_pc !== 32'h0) begin
         tests_failed++; $display("FAIL stall_hold: addr %h inst %h id_pc %h want 00000004 00528333 00000000", imem_addr, id_inst, id_pc);
      end
      id_ex_rd = 5'd0; #1;
      tests_run++;
      if (control_sel !== 1'b0) begin tests_failed++; $display("FAIL stall_rd0: control_sel %b want 0", control_sel); end
      id_ex_rd = 5'd5; id_ex_mem_read = 1'b0; #1;
      tests_run++;
      if (control_sel !== 1'b0) begin tests_failed++; $display("FAIL stall_noload: control_sel %b want 0", control_sel); end

      load_id(32'h0072_8333);              // add x6,x5,x7: rs2=7 used
      id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; #1;
      tests_run++;
      if (control_sel !== 1'b1) begin tests_failed++; $display("FAIL stall_rs2: control_sel %b want 1", control_sel); end

      load_id(32'h0072_8313);              // addi x6,x5,7: rs2 field ignored
      id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; #1;
      tests_run++;
      if (control_sel !== 1'b0) begin tests_failed++; $display("FAIL stall_itype: control_sel %b want 0", control_sel); end

      // Reset during a stall wins.
      id_ex_rd = 5'd5; #1;
      rst = 1'b1; step(); rst = 1'b0;
      tests_run++;
      if (imem_addr !== 32'h0 || id_valid !== 1'b0 || control_sel !== 1'b0) begin
         tests_failed++; $display("FAIL stall_reset: addr %h valid %b control_sel %b want 00000000 0 0", imem_addr, id_valid, control_sel);
      end
   endtask

   task automatic test_branch_flush();
      do_reset();
      for (int i = 0; i < 9; i++) load_id(32'h0000_0013);
      tests_run++;
      if (id_pc !== 32'h20) begin tests_failed++; $display("FAIL br_setup: id_pc %h want 00000020", id_pc); end
      pc_src = 2'b01; branch_target = 32'h40;
      step();
      tests_run++;
      if (imem_addr !== 32'h40 || id_inst !== 32'h13 || id_valid !== 1'b0 || id_pc !== 32'h0) begin
         tests_failed++; $display("FAIL br_flush: addr %h inst %h valid %b id_pc %h want 00000040 00000013 0 00000000", imem_addr, id_inst, id_valid, id_pc);
      end
      pc_src = 2'b00; imem_data = 32'h0010_0093;
      step();
      tests_run++;
      if (id_pc !== 32'h40 || id_valid !== 1'b1 || id_inst !== 32'h0010_0093 || imem_addr !== 32'h44) begin
         tests_failed++; $display("FAIL br_refetch: id_pc %h valid %b inst %h addr %h want 00000040 1 00100093 00000044", id_pc, id_valid, id_inst, imem_addr);
      end
      pc_src = 2'b10;
      step();
      tests_run++;
      if (imem_addr !== 32'h44 || id_pc !== 32'h40) begin
         tests_failed++; $display("FAIL hold: addr %h id_pc %h want 00000044 00000040", imem_addr, id_pc);
      end
   endtask

   task automatic test_jalr_flush();
      do_reset();
      load_id(32'h0000_0013);
      pc_src = 2'b11; jalr_target = 32'h0000_0105;
      step();
      tests_run++;
      if (imem_addr !== 32'h104 || id_inst !== 32'h13 || id_valid !== 1'b0 || id_pc !== 32'h0) begin
         tests_failed++; $display("FAIL jalr: addr %h inst %h valid %b id_pc %h want 00000104 00000013 0 00000000", imem_addr, id_inst, id_valid, id_pc);
      end
   endtask

   task automatic test_halt();
      logic [31:0] frozen;
      int bad;
      do_reset();
      load_id(32'h0000_0013);
      load_id(32'h0000_007F);              // halt now in ID, pc = 8
      frozen = imem_addr;
      pc_src = 2'b01; branch_target = 32'h80;
      step();
      tests_run++;
      if (halted !== 1'b1 || imem_addr !== 32'h8) begin
         tests_failed++; $display("FAIL halt_set: halted %b addr %h want 1 00000008", halted, imem_addr);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         pc_src = (i % 2 == 0) ? 2'b00 : 2'b11;
         step();
         if (imem_addr !== frozen || id_inst !== 32'h7F || id_pc !== 32'h4 || halted !== 1'b1) bad++;
      end
      tests_run++;
      if (bad != 0) begin tests_failed++; $display("FAIL halt_freeze: %0d cycles changed, want 0", bad); end
      rst = 1'b1; step(); rst = 1'b0;
      tests_run++;
      if (halted !== 1'b0 || imem_addr !== 32'h0) begin
         tests_failed++; $display("FAIL halt_reset: halted %b addr %h want 0 00000000", halted, imem_addr);
      end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      pc_src = 2'b01; branch_target = 32'h0000_0042;
      step();
      tests_run++;
      if (imem_addr !== 32'h42) begin tests_failed++; $display("FAIL br_unaligned: addr %h want 00000042", imem_addr); end
      branch_target = 32'hFFFF_FFFC;
      step();
      pc_src = 2'b00;
      step();
      tests_run++;
      if (imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin
         tests_failed++; $display("FAIL pc_wrap: addr %h id_pc %h want 00000000 fffffffc", imem_addr, id_pc);
      end
   endtask

`ifdef IF_ID_PERF_CNT_EN
   task automatic test_perf_cnt();
      do_reset();
      tests_run++;
      if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
         tests_failed++; $display("FAIL perf_reset: stall %0d flush %0d want 0 0", stall_cnt, flush_cnt);
      end
      load_id(32'h0052_8333);
      id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; pc_src = 2'b10;
      for (int i = 0; i < 3; i++) step();
      id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
      pc_src = 2'b01; branch_target = 32'h100; step();
      pc_src = 2'b11; jalr_target = 32'h200; step();
      pc_src = 2'b10; step();
      tests_run++;
      if (stall_cnt !== 32'd3 || flush_cnt !== 32'd2) begin
         tests_failed++; $display("FAIL perf_cnt: stall %0d flush %0d want 3 2", stall_cnt, flush_cnt);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; pc_src = 2'b00; imem_data = 32'h13; branch_target = 32'h0;
      jalr_target = 32'h0; id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
      test_reset();
      test_seq_fetch();
      test_load_use();
      test_branch_flush();
      test_jalr_flush();
      test_halt();
      test_pc_wrap();
`ifdef IF_ID_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register, directly upstream of the decode control unit.
- Owns the PC and drives instruction-memory address.
- Latches the fetched instruction and PC for decode.
- Detects load-use hazards and drives control_sel (bubble request) into control; consumes control's pc_src to redirect, hold or advance the PC.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INST, 32'h00000013, instruction injected into IF/ID on flush/reset (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_addr  output  32  instruction memory address (= current PC)
imem_data  input  32  instruction word at imem_addr, combinational read, same cycle
pc_src  input  2  from control: 00 PC+4, 01 branch_target, 10 hold, 11 jalr_target
branch_target  input  32  id_pc+imm target for branch/jal/halt
jalr_target  input  32  rs1+imm target for jalr
id_ex_mem_read  input  1  instruction in ID/EX is a load
id_ex_rd  input  5  destination register of instruction in ID/EX
id_inst  output  32  IF/ID instruction to control/decode
id_pc  output  32  PC of id_inst
id_valid  output  1  id_inst is a real fetched instruction (0 = injected NOP)
control_sel  output  1  bubble request to control; combinational
halted  output  1  sticky halt flag

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, id_inst=NOP_INST, id_pc=0, id_valid=0, halted=0.
  - control_sel=0 follows because id_valid=0.
- imem_addr=pc combinationally; one-cycle fetch latency (imem_data latched into id_inst at next edge).
- Hazard (combinational): control_sel=1 iff all of:
  - id_valid=1, halted=0, id_ex_mem_read=1, id_ex_rd!=0;
  - id_ex_rd equals id_inst[19:15] (rs1), or equals id_inst[24:20] (rs2) when id_inst[6:0] is 0110011, 0100011 or 1100011.
- Per-edge priority, highest first:
  - rst: reset as above.
  - halted=1: pc, id_inst, id_pc, id_valid all hold.
  - control_sel=1 (stall): pc holds, IF/ID holds. pc_src is 10 from control in this case; hold regardless of its value.
  - Halt in ID (id_valid=1, id_inst[6:0]=1111111): halted<=1, pc holds, IF/ID holds.
  - pc_src=01: pc<=branch_target; IF/ID<=NOP_INST, id_valid<=0, id_pc<=0 (flush wrong-path fetch).
  - pc_src=11: pc<={jalr_target[31:1],1'b0}; same flush.
  - pc_src=10: pc holds, IF/ID holds.
  - pc_src=00: pc<=pc+4 (mod 2^32, wraps 0xFFFFFFFC->0); id_inst<=imem_data, id_pc<=pc, id_valid<=1.
- Redirect penalty: exactly one NOP bubble per taken branch/jal/jalr.
- No alignment check on branch_target; low bits are passed as given.
- rst mid-stall or mid-halt: reset wins; the next cycle fetches RESET_PC.
- halted clears only on rst.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], reset to 0.
  - stall_cnt increments on each edge where control_sel=1 and halted=0.
  - flush_cnt increments on each pc_src 01/11 redirect that is taken.
  - Both wrap at 2^32 and freeze while halted.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then pc_src=00, imem returns 0x00000013 -> imem_addr 0,4,8 on successive cycles; id_pc 0,4 lagging one cycle; id_valid 0 then 1.
- id_inst=0x00528333 (add x6,x5,x5), id_ex_mem_read=1, id_ex_rd=5 -> control_sel=1, imem_addr and id_inst unchanged for that cycle. Repeat with id_ex_rd=0 -> control_sel=0.
- id_pc=0x20, pc_src=01, branch_target=0x40 -> next cycle imem_addr=0x40, id_inst=0x00000013, id_valid=0; following cycle id_pc=0x40.
- pc_src=11, jalr_target=0x00000105 -> imem_addr=0x104 next cycle, IF/ID flushed.
- id_inst=0x0000007F, id_valid=1 -> halted=1 next cycle; imem_addr frozen for 10 cycles; rst -> halted=0, imem_addr=RESET_PC.
- pc=0xFFFFFFFC, pc_src=00 -> imem_addr=0x00000000. With IF_ID_PERF_CNT_EN, 3 stalls + 2 redirects -> stall_cnt=3, flush_cnt=2.
